arc_engine: RTL and testbench

Parametrised midpoint-circle arc rasteriser: the generalised successor of the fixed Reuleaux drawer. It draws any subset of the eight octants of a circle of programmable centre and radius. Every pixel is clipped to the screen and, optionally, to a clip window. It sits between the shape-level controllers (Reuleaux, circle, fill) and the VGA adapter, and emits one candidate pixel per cycle on the standard vga_x/vga_y/vga_colour/vga_plot interface.

---
 rtl/arc_engine_if.sv | 25 ++
 rtl/arc_engine.sv | 192 +++++++++++++++++++
 tb/tb_arc_engine.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc_engine_if.sv
// arc_engine_if: pixel write bus from arc_engine toward the VGA adapter.
// master drives the pixel strobe and coordinates, slave observes them.
interface arc_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;

  modport master (
    output vga_x,
    output vga_y,
    output vga_colour,
    output vga_plot
  );

  modport slave (
    input vga_x,
    input vga_y,
    input vga_colour,
    input vga_plot
  );
endinterface

// File: rtl/arc_engine.sv
// arc_engine: midpoint-circle arc rasteriser over a selectable octant set.
// Define ARC_CLIP_EN to enforce the latched inclusive clip window.
module arc_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  input  logic [7:0]     octant_en,
  input  logic [2:0]     colour,
  input  logic [X_W-1:0] clip_xmin,
  input  logic [X_W-1:0] clip_xmax,
  input  logic [Y_W-1:0] clip_ymin,
  input  logic [Y_W-1:0] clip_ymax,
  output logic           done,
  arc_engine_if.master   vga
);

  localparam int M1 = (X_W > Y_W) ? X_W : Y_W;
  localparam int W  = ((M1 > R_W) ? M1 : R_W) + 2;

  typedef logic signed [W-1:0] s_t;

  localparam s_t ONE   = s_t'(1);
  localparam s_t ZERO  = s_t'(0);
  localparam s_t SCR_W = s_t'(SCREEN_W);
  localparam s_t SCR_H = s_t'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE,
    PLOT,
    UPDATE,
    DONE
  } state_t;

  state_t     state_q;
  logic [2:0] k_q;
  s_t         ox_q;
  s_t         oy_q;
  s_t         crit_q;
  s_t         cx_q;
  s_t         cy_q;
  logic [7:0] oct_q;
  logic [2:0] col_q;

  s_t   px_d;
  s_t   py_d;
  s_t   ox_d;
  s_t   oy_d;
  s_t   crit_d;
  logic on_scr;
  logic in_clip;
  logic plot_d;
  logic fin_d;

  always_comb begin
    px_d = cx_q;
    py_d = cy_q;
    unique case (k_q)
      3'd0: begin px_d = cx_q + ox_q; py_d = cy_q + oy_q; end
      3'd1: begin px_d = cx_q + oy_q; py_d = cy_q + ox_q; end
      3'd2: begin px_d = cx_q - oy_q; py_d = cy_q + ox_q; end
      3'd3: begin px_d = cx_q - ox_q; py_d = cy_q + oy_q; end
      3'd4: begin px_d = cx_q - ox_q; py_d = cy_q - oy_q; end
      3'd5: begin px_d = cx_q - oy_q; py_d = cy_q - ox_q; end
      3'd6: begin px_d = cx_q + oy_q; py_d = cy_q - ox_q; end
      3'd7: begin px_d = cx_q + ox_q; py_d = cy_q - oy_q; end
    endcase
  end

  // Sign bit tested directly so negative coordinates never pass.
  assign on_scr = !px_d[W-1] && (px_d < SCR_W) &&
                  !py_d[W-1] && (py_d < SCR_H);

`ifdef ARC_CLIP_EN
  s_t xmin_q;
  s_t xmax_q;
  s_t ymin_q;
  s_t ymax_q;

  assign in_clip = (px_d >= xmin_q) && (px_d <= xmax_q) &&
                   (py_d >= ymin_q) && (py_d <= ymax_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xmin_q <= ZERO;
      xmax_q <= ZERO;
      ymin_q <= ZERO;
      ymax_q <= ZERO;
    end else if (state_q == IDLE && start) begin
      xmin_q <= s_t'(clip_xmin);
      xmax_q <= s_t'(clip_xmax);
      ymin_q <= s_t'(clip_ymin);
      ymax_q <= s_t'(clip_ymax);
    end
  end
`else
  logic unused_clip;

  assign in_clip     = 1'b1;
  assign unused_clip = ^{clip_xmin, clip_xmax, clip_ymin, clip_ymax};
`endif

  assign plot_d = oct_q[k_q] && on_scr && in_clip;

  always_comb begin
    oy_d = oy_q + ONE;
    ox_d = ox_q;
    if (crit_q <= ZERO) begin
      crit_d = crit_q + (oy_d <<< 1) + ONE;
    end else begin
      ox_d   = ox_q - ONE;
      crit_d = crit_q + ((oy_d - ox_d) <<< 1) + ONE;
    end
  end

  assign fin_d = oy_d > ox_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      k_q            <= 3'd0;
      ox_q           <= ZERO;
      oy_q           <= ZERO;
      crit_q         <= ZERO;
      cx_q           <= ZERO;
      cy_q           <= ZERO;
      oct_q          <= 8'd0;
      col_q          <= 3'd0;
      done           <= 1'b0;
      vga.vga_x      <= '0;
      vga.vga_y      <= '0;
      vga.vga_colour <= 3'd0;
      vga.vga_plot   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          vga.vga_plot <= 1'b0;
          done         <= 1'b0;
          if (start) begin
            cx_q    <= s_t'(centre_x);
            cy_q    <= s_t'(centre_y);
            oct_q   <= octant_en;
            col_q   <= colour;
            ox_q    <= s_t'(radius);
            oy_q    <= ZERO;
            crit_q  <= ONE - s_t'(radius);
            k_q     <= 3'd0;
            state_q <= PLOT;
          end
        end
        PLOT: begin
          vga.vga_x      <= px_d[X_W-1:0];
          vga.vga_y      <= py_d[Y_W-1:0];
          vga.vga_colour <= col_q;
          vga.vga_plot   <= plot_d;
          k_q            <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          vga.vga_plot <= 1'b0;
          ox_q         <= ox_d;
          oy_q         <= oy_d;
          crit_q       <= crit_d;
          if (fin_d) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            state_q <= PLOT;
          end
        end
        DONE: begin
          vga.vga_plot <= 1'b0;
          if (!start) begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc_engine.sv
// tb_arc_engine: table vectors, hand sequences and random arcs
// checked cycle by cycle against an integer midpoint-circle model.
module tb_arc_engine;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int R_W = 8;
  localparam int SW  = 160;
  localparam int SH  = 120;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [X_W-1:0] centre_x = '0;
  logic [Y_W-1:0] centre_y = '0;
  logic [R_W-1:0] radius = '0;
  logic [7:0]     octant_en = '0;
  logic [2:0]     colour = '0;
  logic [X_W-1:0] clip_xmin = '0;
  logic [X_W-1:0] clip_xmax = '0;
  logic [Y_W-1:0] clip_ymin = '0;
  logic [Y_W-1:0] clip_ymax = '0;
  logic           done;

  arc_engine_if #(.X_W(X_W), .Y_W(Y_W)) vga_if ();

  arc_engine #(
    .X_W(X_W), .Y_W(Y_W), .R_W(R_W),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .centre_x(centre_x),
    .centre_y(centre_y),
    .radius(radius),
    .octant_en(octant_en),
    .colour(colour),
    .clip_xmin(clip_xmin),
    .clip_xmax(clip_xmax),
    .clip_ymin(clip_ymin),
    .clip_ymax(clip_ymax),
    .done(done),
    .vga(vga_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cx, cy, r;
    logic [7:0] oct;
    logic [2:0] col;
    int         xmin, xmax, ymin, ymax;
    int         steps, plots, kind;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  int exp_x[$];
  int exp_y[$];
  bit exp_p[$];
  int m_steps;
  int obs_x[$];
  int obs_y[$];
  int done_at;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Plain-integer midpoint circle producing the 8 slot candidates per step.
  task automatic model(input vec_t v);
    int ox, oy, crit, x, y, dx, dy;
    bit p;
    exp_x.delete(); exp_y.delete(); exp_p.delete();
    ox = v.r; oy = 0; crit = 1 - v.r; m_steps = 0;
    do begin
      for (int k = 0; k < 8; k++) begin
        case (k)
          0: begin dx =  ox; dy =  oy; end
          1: begin dx =  oy; dy =  ox; end
          2: begin dx = -oy; dy =  ox; end
          3: begin dx = -ox; dy =  oy; end
          4: begin dx = -ox; dy = -oy; end
          5: begin dx = -oy; dy = -ox; end
          6: begin dx =  oy; dy = -ox; end
          default: begin dx = ox; dy = -oy; end
        endcase
        x = v.cx + dx;
        y = v.cy + dy;
        p = v.oct[k] && x >= 0 && x < SW && y >= 0 && y < SH;
`ifdef ARC_CLIP_EN
        p = p && x >= v.xmin && x <= v.xmax && y >= v.ymin && y <= v.ymax;
`endif
        exp_x.push_back(x & ((1 << X_W) - 1));
        exp_y.push_back(y & ((1 << Y_W) - 1));
        exp_p.push_back(p);
      end
      m_steps++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  task automatic run_arc(input vec_t v, input bit hold);
    int total, s, st, idx;
    model(v);
    obs_x.delete(); obs_y.delete();
    done_at = 0;
    @(negedge clk);
    centre_x  = v.cx[X_W-1:0];
    centre_y  = v.cy[Y_W-1:0];
    radius    = v.r[R_W-1:0];
    octant_en = v.oct;
    colour    = v.col;
    clip_xmin = v.xmin[X_W-1:0];
    clip_xmax = v.xmax[X_W-1:0];
    clip_ymin = v.ymin[Y_W-1:0];
    clip_ymax = v.ymax[Y_W-1:0];
    start     = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    centre_x  = X_W'($urandom);
    centre_y  = Y_W'($urandom);
    radius    = R_W'($urandom);
    octant_en = 8'($urandom);
    colour    = 3'($urandom);
    clip_xmin = X_W'($urandom);
    clip_ymax = Y_W'($urandom);
    total = 9 * m_steps;
    for (int j = 1; j <= total; j++) begin
      @(posedge clk); #1;
      s  = (j - 1) % 9;
      st = (j - 1) / 9;
      if (done && done_at == 0) done_at = j;
      if (s == 8) begin
        chk("upd_plot", int'(vga_if.vga_plot), 0);
      end else begin
        idx = st * 8 + s;
        chk("plot", int'(vga_if.vga_plot), int'(exp_p[idx]));
        chk("x", int'(vga_if.vga_x), exp_x[idx]);
        chk("y", int'(vga_if.vga_y), exp_y[idx]);
        if (exp_p[idx]) chk("colour", int'(vga_if.vga_colour), int'(v.col));
        if (vga_if.vga_plot) begin
          obs_x.push_back(int'(vga_if.vga_x));
          obs_y.push_back(int'(vga_if.vga_y));
        end
      end
    end
    chk("done_edge", done_at, total);
    if (hold) begin
      repeat (4) begin
        @(posedge clk); #1;
        chk("hold_done", int'(done), 1);
        chk("hold_plot", int'(vga_if.vga_plot), 0);
      end
      start = 1'b0;
    end
    @(posedge clk); #1;
    chk("done_clr", int'(done), 0);
  endtask

  function automatic int key(input int dx, input int dy);
    return (dx + 512) * 1024 + (dy + 512);
  endfunction

  task automatic post_checks(input vec_t v);
    bit seen[int];
    int dx, dy, d2, cnt;
    if (v.plots >= 0) chk("plots", obs_x.size(), v.plots);
    if (v.steps >= 0) chk("steps_edge", done_at, 9 * v.steps);
    case (v.kind)
      1: begin
        foreach (obs_x[i]) seen[key(obs_x[i] - v.cx, obs_y[i] - v.cy)] = 1'b1;
        foreach (obs_x[i]) begin
          dx = obs_x[i] - v.cx;
          dy = obs_y[i] - v.cy;
          d2 = dx * dx + dy * dy - v.r * v.r;
          chk("ring", int'(d2 <= v.r && d2 >= -v.r), 1);
          chk("sym", int'(seen.exists(key(-dx, dy)) &&
                          seen.exists(key(dx, -dy)) &&
                          seen.exists(key(dy, dx))), 1);
        end
      end
      2: begin
        chk("inb_some", int'(obs_x.size() > 0), 1);
        foreach (obs_x[i])
          chk("onscreen", int'(obs_x[i] < SW && obs_y[i] < SH), 1);
      end
      3: begin
        cnt = 0;
        foreach (obs_x[i]) if (obs_x[i] < 80) cnt++;
`ifdef ARC_CLIP_EN
        chk("clip_left", cnt, 0);
`else
        chk("clip_full", obs_x.size(), 8 * m_steps);
`endif
      end
      4: begin
        if (obs_x.size() == 2) begin
          chk("r1_x0", obs_x[0], 81);
          chk("r1_y0", obs_y[0], 60);
          chk("r1_x1", obs_x[1], 81);
          chk("r1_y1", obs_y[1], 61);
        end
      end
      default: ;
    endcase
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    vecs[0] = '{80, 60, 0,  8'hFF, 3'd5, 0, 255, 0, 127, 1, 8, 0};
    vecs[1] = '{80, 60, 1,  8'h01, 3'd3, 0, 255, 0, 127, 2, 2, 4};
    vecs[2] = '{80, 60, 40, 8'hFF, 3'd7, 0, 255, 0, 127, -1, -1, 1};
    vecs[3] = '{2,  2,  10, 8'hFF, 3'd1, 0, 255, 0, 127, -1, -1, 2};
    vecs[4] = '{80, 60, 5,  8'h00, 3'd2, 0, 255, 0, 127, -1, 0, 0};
    vecs[5] = '{80, 60, 20, 8'hFF, 3'd6, 80, 200, 0, 127, -1, -1, 3};
    vecs[6] = '{50, 50, 8,  8'hFF, 3'd4, 100, 10, 0, 127, -1, -1, 0};
`ifdef ARC_CLIP_EN
    vecs[6].plots = 0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_plot", int'(vga_if.vga_plot), 0);
    chk("rst_x", int'(vga_if.vga_x), 0);
    chk("rst_y", int'(vga_if.vga_y), 0);
    chk("rst_col", int'(vga_if.vga_colour), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_arc(vecs[i], 1'b0);
      post_checks(vecs[i]);
    end

    // Reset abandons an arc in flight; a held start then draws one arc only.
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20;
    octant_en = 8'hFF; colour = 3'd2; start = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_plot", int'(vga_if.vga_plot), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_x", int'(vga_if.vga_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{80, 60, 20, 8'hFF, 3'd2, 0, 255, 0, 127, -1, -1, 1};
    run_arc(rv, 1'b1);
    post_checks(rv);

    for (int n = 0; n < 12; n++) begin
      rv.cx    = $urandom_range(0, 200);
      rv.cy    = $urandom_range(0, 127);
      rv.r     = $urandom_range(0, 50);
      rv.oct   = 8'($urandom);
      rv.col   = 3'($urandom);
      rv.xmin  = $urandom_range(0, 160);
      rv.xmax  = $urandom_range(0, 255);
      rv.ymin  = $urandom_range(0, 100);
      rv.ymax  = $urandom_range(0, 127);
      rv.steps = -1;
      rv.plots = -1;
      rv.kind  = 0;
      run_arc(rv, n[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
